hist_readout: RTL

Frame-based readout engine for the histogramming design: on `start` it walks every bin of the histogram bin memory, reads each count through a one-cycle-latency read port, and streams the counts out as a byte frame over a valid/ready interface toward the `uo_out` pins. It is the reader opposite the bin-update (writer) logic. Optionally it clears each bin after reading it, so the next acquisition starts from zero.

---
 rtl/hist_pkg.sv | 24 ++
 rtl/hist_readout_if.sv | 44 ++++
 rtl/hist_readout.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/hist_pkg.sv
// Shared types and constants for the histogram reader and bin-update logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hist_pkg;

  // Default geometry, shared with the bin-update (writer) side.
  localparam int HIST_NUM_BINS = 16;
  localparam int HIST_COUNT_W  = 16;

  // First byte of every readout frame.
  localparam logic [7:0] HIST_HDR_BYTE = 8'hA5;

  // Readout sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_LOAD,
    ST_SEND,
    ST_CSUM,
    ST_DONE
  } hist_rd_state_t;

endpackage

// File: rtl/hist_readout_if.sv
// Bin-memory port plus byte-stream port of the histogram reader.
// Latency: n/a (wiring only); rd_data is expected one cycle after rd_en.
// Backpressure: out_ready from the sink; the memory side never stalls.
interface hist_readout_if
  import hist_pkg::*;
#(
  parameter int ADDR_W  = $clog2(HIST_NUM_BINS),
  parameter int COUNT_W = HIST_COUNT_W
);

  // Bin memory read port (one-cycle latency)
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [COUNT_W-1:0] rd_data;

  // Bin memory clear port
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [COUNT_W-1:0] wr_data;

  // Frame byte stream
  logic [7:0]         out_data;
  logic               out_valid;
  logic               out_ready;

  // Reader side
  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output wr_en, wr_addr, wr_data,
    output out_data, out_valid,
    input  out_ready
  );

  // Memory / sink side
  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  wr_en, wr_addr, wr_data,
    input  out_data, out_valid,
    output out_ready
  );

endinterface

// File: rtl/hist_readout.sv
// Walks all histogram bins and streams them as a byte frame: A5, counts MSB first, XOR checksum.
// Latency: header on the bus the cycle after start; each bin costs 2 + COUNT_W/8 cycles at full rate.
// Backpressure: out_valid/out_data hold until out_ready; outputs depend only on registered state.
module hist_readout
  import hist_pkg::*;
#(
  parameter int NUM_BINS = HIST_NUM_BINS,
  parameter int COUNT_W  = HIST_COUNT_W,
  parameter int ADDR_W   = $clog2(NUM_BINS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             clr_mode,
  output logic             busy,
  output logic             done,
  hist_readout_if.master   bus
);

  localparam int NBYTES = COUNT_W / 8;
  localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(NBYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BINS - 1);

  hist_rd_state_t     state_q, state_d;
  logic [ADDR_W-1:0]  addr_q,  addr_d;
  logic [COUNT_W-1:0] shift_q, shift_d;
  logic [BIDX_W-1:0]  bidx_q,  bidx_d;
  logic [7:0]         csum_q,  csum_d;
  logic               clr_q,   clr_d;

  logic               rd_en_c;
  logic               wr_en_c;
  logic               out_vld_c;
  logic [7:0]         out_dat_c;
  logic               done_c;
  logic [7:0]         top_byte;

  assign top_byte = shift_q[COUNT_W-1 -: 8];

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      shift_q <= '0;
      bidx_q  <= '0;
      csum_q  <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      bidx_q  <= bidx_d;
      csum_q  <= csum_d;
      clr_q   <= clr_d;
    end
  end

  // Next-state logic and output decode from the registered state.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    shift_d   = shift_q;
    bidx_d    = bidx_q;
    csum_d    = csum_q;
    clr_d     = clr_q;
    rd_en_c   = 1'b0;
    wr_en_c   = 1'b0;
    out_vld_c = 1'b0;
    out_dat_c = 8'h00;
    done_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // ena only qualifies the start request; it never stalls a running frame
        if (start && ena) begin
          state_d = ST_HDR;
          clr_d   = clr_mode;
          csum_d  = '0;
          addr_d  = '0;
        end
      end

      ST_HDR: begin
        out_vld_c = 1'b1;
        out_dat_c = HIST_HDR_BYTE;
        if (bus.out_ready) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        rd_en_c = 1'b1;
        state_d = ST_LOAD;
      end

      ST_LOAD: begin
        // read data lands exactly now; the clear write targets the same bin
        shift_d = bus.rd_data;
        bidx_d  = '0;
        wr_en_c = clr_q;
        state_d = ST_SEND;
      end

      ST_SEND: begin
        out_vld_c = 1'b1;
        out_dat_c = top_byte;
        if (bus.out_ready) begin
          csum_d  = csum_q ^ top_byte;
          shift_d = shift_q << 8;
          bidx_d  = bidx_q + 1'b1;
          if (bidx_q == LAST_BYTE) begin
            // the address saturates at the last bin; the frame ends instead of wrapping
            if (addr_q == LAST_ADDR) begin
              state_d = ST_CSUM;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = ST_FETCH;
            end
          end
        end
      end

      ST_CSUM: begin
        out_vld_c = 1'b1;
        out_dat_c = csum_q;
        if (bus.out_ready) state_d = ST_DONE;
      end

      ST_DONE: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Addresses are gated by their strobes so idle outputs sit at zero.
  assign bus.rd_en     = rd_en_c;
  assign bus.rd_addr   = rd_en_c ? addr_q : '0;
  assign bus.wr_en     = wr_en_c;
  assign bus.wr_addr   = wr_en_c ? addr_q : '0;
  assign bus.wr_data   = '0;
  assign bus.out_valid = out_vld_c;
  assign bus.out_data  = out_dat_c;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_c;

endmodule
